// File: rtl/river_crossing_engine.sv
// Interactive Missionaries-and-Cannibals engine: legality checks, bank tracking, win/loss detection.
// Optional undo history is enabled by defining RIVER_UNDO_EN.
module river_crossing_engine #(
   parameter int N          = 3,
   parameter int CAP        = 2,
   parameter int CNT_W      = 3,
   parameter int STEP_W     = 6,
   parameter int HIST_DEPTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              move_valid,
   input  logic [CNT_W-1:0]  move_m,
   input  logic [CNT_W-1:0]  move_c,
   output logic              move_ready,
   input  logic              undo,
   output logic              move_ack,
   output logic              move_err,
   output logic [1:0]        err_code,
   output logic [CNT_W-1:0]  missionaries_left,
   output logic [CNT_W-1:0]  cannibals_left,
   output logic [CNT_W-1:0]  missionaries_right,
   output logic [CNT_W-1:0]  cannibals_right,
   output logic              boat_side,
   output logic [STEP_W-1:0] step_count,
   output logic [1:0]        phase,
   output logic              solved,
   output logic              lost
);

   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, WON = 2'd2, LOST = 2'd3} phase_t;

   phase_t             phase_reg, phase_next;
   logic [CNT_W-1:0]   ml_reg, cl_reg, mr_reg, cr_reg;
   logic [CNT_W-1:0]   ml_next, cl_next, mr_next, cr_next;
   logic               boat_reg, boat_next;
   logic [STEP_W-1:0]  step_reg, step_next;
   logic               ack_reg, ack_next, err_reg, err_next;
   logic [1:0]         code_reg, code_next;

   logic               undo_in, undo_go, hist_empty;
   logic               push_en, pop_en, clr_en, xfer;
   logic [CNT_W-1:0]   top_m, top_c, amt_m, amt_c, src_m, src_c;
   logic [CNT_W:0]     sum;

   assign move_ready = (phase_reg == PLAY) && !undo_in && !start;
   assign undo_go    = undo_in && !start && ((phase_reg == PLAY) || (phase_reg == LOST));

   always_comb begin
      ml_next    = ml_reg;
      cl_next    = cl_reg;
      mr_next    = mr_reg;
      cr_next    = cr_reg;
      boat_next  = boat_reg;
      step_next  = step_reg;
      phase_next = phase_reg;
      ack_next   = 1'b0;
      err_next   = 1'b0;
      code_next  = code_reg;
      push_en    = 1'b0;
      pop_en     = 1'b0;
      clr_en     = 1'b0;
      xfer       = 1'b0;
      amt_m      = move_m;
      amt_c      = move_c;
      src_m      = boat_reg ? mr_reg : ml_reg;
      src_c      = boat_reg ? cr_reg : cl_reg;
      sum        = {1'b0, move_m} + {1'b0, move_c};

      if (start) begin
         ml_next    = CNT_W'(N);
         cl_next    = CNT_W'(N);
         mr_next    = '0;
         cr_next    = '0;
         boat_next  = 1'b0;
         step_next  = '0;
         phase_next = PLAY;
         clr_en     = 1'b1;
      end else if (undo_go) begin
         if (hist_empty) begin
            err_next  = 1'b1;
            code_next = 2'b11;
         end else begin
            amt_m      = top_m;
            amt_c      = top_c;
            xfer       = 1'b1;
            pop_en     = 1'b1;
            ack_next   = 1'b1;
            code_next  = 2'b00;
            phase_next = PLAY;
            step_next  = (step_reg == '0) ? '0 : step_reg - STEP_W'(1);
         end
      end else if (move_valid && move_ready) begin
         if ((sum == '0) || (sum > (CNT_W+1)'(CAP))) begin
            err_next  = 1'b1;
            code_next = 2'b01;
         end else if ((src_m < move_m) || (src_c < move_c)) begin
            err_next  = 1'b1;
            code_next = 2'b10;
         end else begin
            xfer      = 1'b1;
            push_en   = 1'b1;
            ack_next  = 1'b1;
            code_next = 2'b00;
            step_next = (&step_reg) ? step_reg : step_reg + STEP_W'(1);
         end
      end

      // Boat always carries people away from its current bank; undo replays the last load backwards.
      if (xfer) begin
         if (boat_reg) begin
            mr_next = mr_reg - amt_m;
            cr_next = cr_reg - amt_c;
            ml_next = ml_reg + amt_m;
            cl_next = cl_reg + amt_c;
         end else begin
            ml_next = ml_reg - amt_m;
            cl_next = cl_reg - amt_c;
            mr_next = mr_reg + amt_m;
            cr_next = cr_reg + amt_c;
         end
         boat_next = !boat_reg;
      end

      if (push_en) begin
         if (((ml_next != '0) && (cl_next > ml_next)) || ((mr_next != '0) && (cr_next > mr_next)))
            phase_next = LOST;
         else if ((mr_next == CNT_W'(N)) && (cr_next == CNT_W'(N)))
            phase_next = WON;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ml_reg    <= CNT_W'(N);
         cl_reg    <= CNT_W'(N);
         mr_reg    <= '0;
         cr_reg    <= '0;
         boat_reg  <= 1'b0;
         step_reg  <= '0;
         phase_reg <= IDLE;
         ack_reg   <= 1'b0;
         err_reg   <= 1'b0;
         code_reg  <= 2'b00;
      end else begin
         ml_reg    <= ml_next;
         cl_reg    <= cl_next;
         mr_reg    <= mr_next;
         cr_reg    <= cr_next;
         boat_reg  <= boat_next;
         step_reg  <= step_next;
         phase_reg <= phase_next;
         ack_reg   <= ack_next;
         err_reg   <= err_next;
         code_reg  <= code_next;
      end
   end

`ifdef RIVER_UNDO_EN
   localparam int PW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
   localparam int DW = $clog2(HIST_DEPTH + 1);

   // Ring buffer used as a LIFO so an overflow silently overwrites the oldest entry.
   logic [2*CNT_W-1:0] hist_mem [HIST_DEPTH];
   logic [PW-1:0]      ptr_reg, ptr_inc, ptr_dec;
   logic [DW-1:0]      depth_reg;

   assign undo_in        = undo;
   assign ptr_inc        = (ptr_reg == PW'(HIST_DEPTH - 1)) ? '0 : ptr_reg + PW'(1);
   assign ptr_dec        = (ptr_reg == '0) ? PW'(HIST_DEPTH - 1) : ptr_reg - PW'(1);
   assign hist_empty     = (depth_reg == '0);
   assign {top_m, top_c} = hist_mem[ptr_dec];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_reg   <= '0;
         depth_reg <= '0;
      end else if (clr_en) begin
         ptr_reg   <= '0;
         depth_reg <= '0;
      end else if (push_en) begin
         ptr_reg <= ptr_inc;
         if (depth_reg != DW'(HIST_DEPTH))
            depth_reg <= depth_reg + DW'(1);
      end else if (pop_en) begin
         ptr_reg   <= ptr_dec;
         depth_reg <= depth_reg - DW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_en)
         hist_mem[ptr_reg] <= {move_m, move_c};
   end
`else
   logic unused_undo;
   assign undo_in     = 1'b0;
   assign hist_empty  = 1'b1;
   assign top_m       = '0;
   assign top_c       = '0;
   assign unused_undo = undo | pop_en | clr_en | (HIST_DEPTH == 0);
`endif

   assign move_ack           = ack_reg;
   assign move_err           = err_reg;
   assign err_code           = code_reg;
   assign missionaries_left  = ml_reg;
   assign cannibals_left     = cl_reg;
   assign missionaries_right = mr_reg;
   assign cannibals_right    = cr_reg;
   assign boat_side          = boat_reg;
   assign step_count         = step_reg;
   assign phase              = phase_reg;
   assign solved             = (phase_reg == WON);
   assign lost               = (phase_reg == LOST);

endmodule

// File: tb/tb_river_crossing_engine.sv
// Bench for river_crossing_engine: bank-level game model checked every cycle, directed scenarios
// with literal expectations, then randomized play. Honours RIVER_UNDO_EN like the design.
module tb_river_crossing_engine;
   localparam int N = 3, CAP = 2, CNT_W = 3, STEP_W = 6, HIST_DEPTH = 16;
`ifdef RIVER_UNDO_EN
   localparam bit UNDO_EN = 1'b1;
`else
   localparam bit UNDO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, start, move_valid, undo;
   logic [CNT_W-1:0] move_m, move_c;
   logic move_ready, move_ack, move_err, boat_side, solved, lost;
   logic [1:0] err_code, phase;
   logic [CNT_W-1:0] missionaries_left, cannibals_left, missionaries_right, cannibals_right;
   logic [STEP_W-1:0] step_count;

   always #5 clk = ~clk;

   river_crossing_engine #(.N(N), .CAP(CAP), .CNT_W(CNT_W), .STEP_W(STEP_W), .HIST_DEPTH(HIST_DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .move_valid(move_valid),
      .move_m(move_m), .move_c(move_c), .move_ready(move_ready), .undo(undo),
      .move_ack(move_ack), .move_err(move_err), .err_code(err_code),
      .missionaries_left(missionaries_left), .cannibals_left(cannibals_left),
      .missionaries_right(missionaries_right), .cannibals_right(cannibals_right),
      .boat_side(boat_side), .step_count(step_count), .phase(phase),
      .solved(solved), .lost(lost)
   );

   int checks = 0, errors = 0;
   // Model: index 0 = left bank, 1 = right bank; phase 0..3 as IDLE/PLAY/WON/LOST.
   int bm[2], bc[2];
   int mboat, mstep, mph, mcode;
   bit mack, merr, chk_en = 1'b0;
   int hist[$];

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      bm[0] = N; bc[0] = N; bm[1] = 0; bc[1] = 0;
      mboat = 0; mstep = 0; mph = 0; mcode = 0; mack = 0; merr = 0;
      hist.delete();
   endtask

   function automatic bit exp_ready();
      return (mph == 1) && !start && !(UNDO_EN && undo);
   endfunction

   function automatic bit unsafe(int m, int c);
      return (m > 0) && (c > m);
   endfunction

   task automatic model_edge();
      int e, hm, hc, tgt, m, c;
      mack = 0; merr = 0;
      m = int'(move_m); c = int'(move_c);
      if (reset) begin
         model_reset();
      end else if (start) begin
         bm[0] = N; bc[0] = N; bm[1] = 0; bc[1] = 0;
         mboat = 0; mstep = 0; mph = 1;
         hist.delete();
      end else if (UNDO_EN && undo && (mph == 1 || mph == 3)) begin
         if (hist.size() == 0) begin
            merr = 1; mcode = 3;
         end else begin
            e = hist.pop_back();
            hm = e / 8; hc = e % 8; tgt = 1 - mboat;
            bm[mboat] -= hm; bc[mboat] -= hc; bm[tgt] += hm; bc[tgt] += hc;
            mboat = tgt;
            if (mstep > 0) mstep--;
            mph = 1; mack = 1; mcode = 0;
         end
      end else if (move_valid && exp_ready()) begin
         if (m + c == 0 || m + c > CAP) begin
            merr = 1; mcode = 1;
         end else if (bm[mboat] < m || bc[mboat] < c) begin
            merr = 1; mcode = 2;
         end else begin
            tgt = 1 - mboat;
            bm[mboat] -= m; bc[mboat] -= c; bm[tgt] += m; bc[tgt] += c;
            mboat = tgt;
            if (mstep < (1 << STEP_W) - 1) mstep++;
            hist.push_back(m * 8 + c);
            if (hist.size() > HIST_DEPTH) void'(hist.pop_front());
            mack = 1; mcode = 0;
            if (unsafe(bm[0], bc[0]) || unsafe(bm[1], bc[1])) mph = 3;
            else if (bm[1] == N && bc[1] == N) mph = 2;
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("missionaries_left", missionaries_left, bm[0]);
         check("cannibals_left", cannibals_left, bc[0]);
         check("missionaries_right", missionaries_right, bm[1]);
         check("cannibals_right", cannibals_right, bc[1]);
         check("boat_side", boat_side, mboat);
         check("step_count", step_count, mstep);
         check("phase", phase, mph);
         check("solved", solved, mph == 2);
         check("lost", lost, mph == 3);
         check("move_ack", move_ack, mack);
         check("move_err", move_err, merr);
         check("err_code", err_code, mcode);
         check("move_ready", move_ready, exp_ready());
      end
   end

   task automatic cycle(bit s, bit v, int m, int c, bit u);
      start = s; move_valid = v; move_m = 3'(m); move_c = 3'(c); undo = u;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   int sol_m[11] = '{0, 0, 0, 0, 2, 1, 2, 0, 0, 0, 0};
   int sol_c[11] = '{2, 1, 2, 1, 0, 1, 0, 1, 2, 1, 2};

   initial begin
      reset = 1'b1; start = 1'b0; move_valid = 1'b0; undo = 1'b0; move_m = '0; move_c = '0;
      model_reset();
      chk_en = 1'b1;
      repeat (2) cycle(0, 0, 0, 0, 0);
      check("rst_phase", phase, 0);
      check("rst_ml", missionaries_left, 3);
      check("rst_mr", missionaries_right, 0);
      check("rst_ack", move_ack, 0);
      reset = 1'b0;
      cycle(0, 1, 0, 1, 0);
      check("idle_move_ack", move_ack, 0);
      check("idle_move_err", move_err, 0);

      // Full solution
      cycle(1, 0, 0, 0, 0);
      check("start_phase", phase, 1);
      for (int i = 0; i < 11; i++) begin
         cycle(0, 1, sol_m[i], sol_c[i], 0);
         check("sol_ack", move_ack, 1);
      end
      check("sol_ml", missionaries_left, 0);
      check("sol_cl", cannibals_left, 0);
      check("sol_mr", missionaries_right, 3);
      check("sol_cr", cannibals_right, 3);
      check("sol_boat", boat_side, 1);
      check("sol_step", step_count, 11);
      check("sol_phase", phase, 2);
      check("sol_solved", solved, 1);
      check("sol_ready", move_ready, 0);

      // Capacity rejects
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 2, 1, 0);
      check("cap_err1", move_err, 1);
      check("cap_code1", err_code, 1);
      cycle(0, 1, 0, 0, 0);
      check("cap_err2", move_err, 1);
      check("cap_code2", err_code, 1);
      check("cap_ml", missionaries_left, 3);
      check("cap_step", step_count, 0);

      // Source reject with boat on the right
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 0, 2, 0);
      cycle(0, 1, 1, 0, 0);
      check("src_err", move_err, 1);
      check("src_code", err_code, 2);
      check("src_cl", cannibals_left, 1);
      check("src_cr", cannibals_right, 2);

      // Losing move
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 2, 0, 0);
      check("lose_ack", move_ack, 1);
      check("lose_ml", missionaries_left, 1);
      check("lose_cl", cannibals_left, 3);
      check("lose_mr", missionaries_right, 2);
      check("lose_phase", phase, 3);
      check("lose_lost", lost, 1);
      cycle(0, 1, 0, 1, 0);
      check("lost_ignored_ack", move_ack, 0);
      check("lost_ignored_err", move_err, 0);
`ifdef RIVER_UNDO_EN
      cycle(0, 0, 0, 0, 1);
      check("undo_ack", move_ack, 1);
      check("undo_ml", missionaries_left, 3);
      check("undo_cr", cannibals_right, 0);
      check("undo_boat", boat_side, 0);
      check("undo_step", step_count, 0);
      check("undo_phase", phase, 1);
      cycle(0, 0, 0, 0, 1);
      check("undo_empty_err", move_err, 1);
      check("undo_empty_code", err_code, 3);
`endif

      // start beats move_valid, then asynchronous reset mid-cycle
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 0, 2, 0);
      cycle(1, 1, 1, 1, 0);
      check("restart_ack", move_ack, 0);
      check("restart_err", move_err, 0);
      check("restart_cl", cannibals_left, 3);
      check("restart_phase", phase, 1);
      cycle(0, 1, 0, 2, 0);
      check("pre_reset_ack", move_ack, 1);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check("async_ack", move_ack, 0);
      check("async_cl", cannibals_left, 3);
      check("async_cr", cannibals_right, 0);
      check("async_boat", boat_side, 0);
      check("async_step", step_count, 0);
      check("async_phase", phase, 0);
      cycle(0, 0, 0, 0, 0);
      reset = 1'b0;
      cycle(0, 0, 0, 0, 0);

      // Step saturation and history overflow
      cycle(1, 0, 0, 0, 0);
      repeat (70) cycle(0, 1, 0, 1, 0);
      check("sat_step", step_count, 63);
`ifdef RIVER_UNDO_EN
      for (int i = 0; i < 16; i++) begin
         cycle(0, 0, 0, 0, 1);
         check("hist_undo_ack", move_ack, 1);
      end
      check("hist_step", step_count, 47);
      cycle(0, 0, 0, 0, 1);
      check("hist_overflow_err", move_err, 1);
      check("hist_overflow_code", err_code, 3);
`endif

      // Randomized play
      for (int i = 0; i < 3000; i++) begin
         bit s, v, u;
         s = (mph >= 2 || mph == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 39) == 0);
         v = ($urandom_range(0, 3) != 0);
         u = ($urandom_range(0, 7) == 0);
         cycle(s, v, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), u);
      end

      cycle(0, 0, 0, 0, 0);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/river_crossing_engine.md
Name: river_crossing_engine

Overview:
- Interactive, parametrised Missionaries-and-Cannibals game engine. It succeeds the fixed 12-state solution sequencer.
- Supports N missionaries plus N cannibals and a boat of capacity CAP.
- Accepts arbitrary move commands over a valid/ready handshake and checks each move for legality.
- Maintains the two bank counts and detects win and loss.
- Sits between the board's button/switch decoder (move source) and the 7-segment/LED display block (bank counts, phase).

Parameters:
- N, 3, number of missionaries and number of cannibals (1..7).
- CAP, 2, boat capacity in persons (1..7).
- CNT_W, 3, width of all person-count fields; must hold N.
- STEP_W, 6, width of the step counter.
- HIST_DEPTH, 16, move-history entries; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle pulse; (re)initialises the game
- move_valid  in  1  move command present
- move_m  in  CNT_W  missionaries carried by the boat
- move_c  in  CNT_W  cannibals carried by the boat
- move_ready  out  1  engine can accept a move
- undo  in  1  single-cycle undo request (optional feature)
- move_ack  out  1  one-cycle pulse: command applied
- move_err  out  1  one-cycle pulse: command rejected
- err_code  out  2  reason for the last reject; holds until the next ack or err
- missionaries_left, cannibals_left, missionaries_right, cannibals_right  out  CNT_W each  bank counts
- boat_side  out  1  0 = left bank, 1 = right bank
- step_count  out  STEP_W  number of applied moves
- phase  out  2  0 = IDLE, 1 = PLAY, 2 = WON, 3 = LOST
- solved  out  1  phase == WON
- lost  out  1  phase == LOST

Behaviour:
- Reset (async): left banks = N, right banks = 0, boat_side = 0, step_count = 0, phase = IDLE, move_ack = 0, move_err = 0, err_code = 0, history empty.
- start, in any phase: on the next edge, banks/boat/step/history return to reset values and phase = PLAY. start beats move_valid and undo in the same cycle; the move is dropped with no ack and no err.
- move_ready = (phase == PLAY) && !undo && !start. This is combinational.
- Handshake: a move is accepted on a clk edge where move_valid && move_ready. The result is registered with 1-cycle latency: counts, boat, step, phase and the ack/err pulse all update on that same edge and are visible in the following cycle.
- move_valid outside PLAY is ignored: no ack, no err.
- Check priority on an accepted move:
  - 1. Capacity check: if (move_m + move_c) == 0 or > CAP, then err_code = 01.
  - 2. Source check: if the boat-side bank has fewer than move_m missionaries or fewer than move_c cannibals, then err_code = 10.
  - A rejected move pulses move_err and changes no state.
- Sums use CNT_W+1 bits; no overflow is allowed.
- Legal move:
  - Subtract the carried persons from the boat-side bank and add them to the other bank.
  - Toggle boat_side.
  - step_count += 1, saturating at all-ones.
  - Pulse move_ack.
- Post-move evaluation, on the same edge:
  - If either bank has m > 0 && c > m, then phase = LOST.
  - Otherwise, if the right bank holds N missionaries and N cannibals, then phase = WON.
  - Otherwise phase stays PLAY.
- WON and LOST are absorbing; only start, reset or undo (feature) leave them.
- Reset asserted mid-move aborts immediately; no ack is issued.

Optional Feature:
- Macro RIVER_UNDO_EN.
- When defined:
  - A LIFO of HIST_DEPTH entries stores {move_m, move_c} for each applied move.
  - On overflow the oldest entry is discarded; the stack depth saturates at HIST_DEPTH.
  - An undo pulse in PLAY or LOST with a non-empty stack reverses the last move: the persons move back, boat_side toggles, step_count -= 1 (floor 0), phase = PLAY, and move_ack pulses.
  - An undo on an empty stack gives move_err with err_code = 11.
  - undo is ignored in IDLE and WON.
  - undo beats move_valid in the same cycle.
- When undefined: the undo input is ignored, no history storage is built, and err_code 11 never occurs.

Test Plan:
- N=3, CAP=2. Reset, start, then apply moves (0,2)(0,1)(0,2)(0,1)(2,0)(1,1)(2,0)(0,1)(0,2)(0,1)(0,2). Required: 11 acks, final banks 0,0 | 3,3, boat_side = 1, step_count = 11, phase = 2, solved = 1, move_ready = 0.
- After start, move (2,1), then move (0,0). Required: two move_err pulses, err_code = 01, banks stay 3,3 | 0,0, step_count = 0.
- After start and (0,2), issue move (1,0) with the boat on the right. Required: move_err, err_code = 10, banks stay 3,1 | 0,2.
- After start, move (2,0). Required: ack, banks 1,3 | 2,0, phase = 3, lost = 1. A further move_valid produces no response.
- RIVER_UNDO_EN, continuing the previous scenario:
  - undo → banks 3,3 | 0,0, boat_side = 0, step_count = 0, phase = 1.
  - undo again → move_err, err_code = 11.
- Mid-PLAY, assert start and move_valid (1,1) in the same cycle. Required: reinitialised game, no ack, no err. Then assert reset asynchronously mid-cycle. Required: all outputs at reset values before the next edge.
